// File: rtl/mem_stage_lsu.sv
// ============================================================================
// mem_stage_lsu : MEM-stage load/store unit, req/ack data bus with timeout.
// Optional build macro MEM_MISALIGN_TRAP_EN enables misaligned-access trapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_lsu #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic [31:0] load_data_o,
  output logic        stall_o,
  output logic        bus_err_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             req_read;
  logic [2:0]       req_f3;
  logic [1:0]       req_lo;

  logic             access;
  logic             trap;
  logic [3:0]       be_calc;
  logic [31:0]      wdata_calc;
  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic [31:0]      load_ext;
  logic             timeout_hit;
  logic             stall;
  logic             start;
  logic             finish_ok;
  logic             finish_to;
  logic             trap_now;

  assign access      = mem_read_i | mem_write_i;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = access &&
                (((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                 (funct3_i[1] && (addr_i[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr_i[1:0];
        wdata_calc = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_calc = {2{wdata_i[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata_i;
      end
    endcase
  end

  // Lane selection uses the address latched at request time, not the live input.
  always_comb begin
    lane_byte = dbus_rdata[7:0];
    case (req_lo)
      2'd0:    lane_byte = dbus_rdata[7:0];
      2'd1:    lane_byte = dbus_rdata[15:8];
      2'd2:    lane_byte = dbus_rdata[23:16];
      default: lane_byte = dbus_rdata[31:24];
    endcase
    lane_half = req_lo[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    if (req_f3[1]) begin
      load_ext = dbus_rdata;
    end else if (req_f3[0]) begin
      load_ext = {{16{lane_half[15] & ~req_f3[2]}}, lane_half};
    end else begin
      load_ext = {{24{lane_byte[7] & ~req_f3[2]}}, lane_byte};
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    start      = 1'b0;
    finish_ok  = 1'b0;
    finish_to  = 1'b0;
    trap_now   = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (trap) begin
            trap_now = 1'b1;
          end else begin
            start      = 1'b1;
            stall      = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (dbus_ack) begin
          finish_ok  = 1'b1;
          state_next = DONE;
        end else if (timeout_hit) begin
          finish_to  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign stall_o = stall & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      req_read    <= 1'b0;
      req_f3      <= 3'b000;
      req_lo      <= 2'b00;
      dbus_req    <= 1'b0;
      dbus_we     <= 1'b0;
      dbus_addr   <= 32'h0;
      dbus_be     <= 4'h0;
      dbus_wdata  <= 32'h0;
      load_data_o <= 32'h0;
      bus_err_o   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= (state == WAIT) ? cnt + 1'b1 : '0;
      if (start) begin
        dbus_req   <= 1'b1;
        dbus_we    <= mem_write_i;
        dbus_addr  <= {addr_i[31:2], 2'b00};
        dbus_be    <= be_calc;
        dbus_wdata <= wdata_calc;
        req_read   <= mem_read_i & ~mem_write_i;
        req_f3     <= funct3_i;
        req_lo     <= addr_i[1:0];
      end
      if (finish_ok) begin
        dbus_req <= 1'b0;
        if (req_read) begin
          load_data_o <= load_ext;
        end
      end
      if (finish_to) begin
        dbus_req    <= 1'b0;
        bus_err_o   <= 1'b1;
        load_data_o <= 32'h0;
      end
      if (state == DONE) begin
        bus_err_o <= 1'b0;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= trap_now;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
// tb_mem_stage_lsu : scoreboard bench for mem_stage_lsu (directed vectors).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_lsu;

  localparam int TO = 16;

  logic        clk;
  logic        reset;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic [31:0] load_data_o;
  logic        stall_o;
  logic        bus_err_o;
  logic        misalign_o;

  mem_stage_lsu #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read_i  (mem_read_i),
    .mem_write_i (mem_write_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .dbus_req    (dbus_req),
    .dbus_we     (dbus_we),
    .dbus_addr   (dbus_addr),
    .dbus_be     (dbus_be),
    .dbus_wdata  (dbus_wdata),
    .dbus_ack    (dbus_ack),
    .dbus_rdata  (dbus_rdata),
    .load_data_o (load_data_o),
    .stall_o     (stall_o),
    .bus_err_o   (bus_err_o),
    .misalign_o  (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] ld;
    logic        err;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   tests  = 0;
  int   failed = 0;
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: request fields on each new request, results on each completion.
  always @(negedge clk) begin
    if (dbus_req && !prev_req) begin
      if (req_q.size() == 0) begin
        check("unexpected_req", 32'd1, 32'd0);
      end else begin
        req_t e;
        e = req_q.pop_front();
        check("req_we",    {31'd0, dbus_we}, {31'd0, e.we});
        check("req_addr",  dbus_addr, e.addr);
        check("req_be",    {28'd0, dbus_be}, {28'd0, e.be});
        check("req_wdata", dbus_wdata, e.wdata);
      end
    end
    if (prev_req && !dbus_req && !reset) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        check("load_data", load_data_o, r.ld);
        check("bus_err",   {31'd0, bus_err_o}, {31'd0, r.err});
        check("done_stall", {31'd0, stall_o}, 32'd0);
      end
    end
    prev_req = dbus_req;
  end

  // ack_at: WAIT cycle (1-based) in which ack is given; 0 means never.
  task automatic txn(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdw,
                     input int ack_at, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                     input logic [31:0] exp_wd, input logic [31:0] exp_ld, input logic exp_err);
    int   stalls;
    int   reqs;
    logic pr;
    logic done;
    req_t e;
    rsp_t r;
    e.we = wr; e.addr = exp_addr; e.be = exp_be; e.wdata = exp_wd;
    r.ld = exp_ld; r.err = exp_err;
    req_q.push_back(e);
    rsp_q.push_back(r);
    stalls = 0; reqs = 0; pr = dbus_req; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a; wdata_i = wd;
      end
      dbus_rdata = rdw;
      dbus_ack   = (ack_at > 0) && (c == ack_at);
      @(negedge clk);
      if (stall_o) stalls++;
      if (dbus_req && !pr) reqs++;
      pr = dbus_req;
      if (c > 0 && !stall_o) done = 1'b1;
    end
    if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
    check({name, "_stall_cycles"}, 32'(stalls), (ack_at > 0) ? 32'(ack_at + 1) : 32'(TO + 1));
    check({name, "_req_pulses"}, 32'(reqs), 32'd1);
    @(posedge clk); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0; dbus_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b000;
    addr_i = 32'h0; wdata_i = 32'h0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 mem_read_i = 1'b1;
    @(negedge clk);
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    check("reset_req",   {31'd0, dbus_req}, 32'd0);
    check("reset_addr",  dbus_addr, 32'h0);
    check("reset_be",    {28'd0, dbus_be}, 32'd0);
    check("reset_wdata", dbus_wdata, 32'h0);
    check("reset_ld",    load_data_o, 32'h0);
    check("reset_err",   {31'd0, bus_err_o}, 32'd0);
    check("reset_mis",   {31'd0, misalign_o}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; mem_read_i = 1'b0;

    txn("sw",  1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 2,
        32'h104, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    txn("sb",  1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 1,
        32'h200, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0);
    txn("sh",  1'b0, 1'b1, 3'b001, 32'h106, 32'h1234CAFE, 32'h0, 1,
        32'h104, 4'b1100, 32'hCAFECAFE, 32'h0, 1'b0);
    txn("lb",  1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h00008000, 1,
        32'h100, 4'b0010, 32'h00000000, 32'hFFFFFF80, 1'b0);
    txn("lbu", 1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 32'h00008000, 3,
        32'h100, 4'b0010, 32'h00000000, 32'h00000080, 1'b0);
    txn("lh",  1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 1,
        32'h100, 4'b1100, 32'h00000000, 32'hFFFF8001, 1'b0);
    txn("lhu", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80011234, 2,
        32'h100, 4'b1100, 32'h00000000, 32'h00008001, 1'b0);
    txn("rw_both", 1'b1, 1'b1, 3'b010, 32'h10C, 32'h0BADF00D, 32'hFFFFFFFF, 1,
        32'h10C, 4'b1111, 32'h0BADF00D, 32'h00008001, 1'b0);
    txn("lw",  1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 32'h13579BDF, 1,
        32'h108, 4'b1111, 32'h00000000, 32'h13579BDF, 1'b0);
    txn("lw_to", 1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, 32'h0, 0,
        32'h10C, 4'b1111, 32'h00000000, 32'h00000000, 1'b1);
    @(negedge clk);
    check("err_one_cycle", {31'd0, bus_err_o}, 32'd0);
    check("idle_stall",    {31'd0, stall_o}, 32'd0);

    // Reset during the second WAIT cycle of a load.
    req_q.push_back('{1'b0, 32'h110, 4'b1111, 32'h0});
    @(posedge clk); #1;
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h110;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_wait_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    check("rst_req_drop", {31'd0, dbus_req}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; mem_read_i = 1'b0;
    dbus_ack = 1'b1; dbus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req",   {31'd0, dbus_req}, 32'd0);
    check("late_ack_stall", {31'd0, stall_o}, 32'd0);
    check("late_ack_ld",    load_data_o, 32'h0);

`ifdef MEM_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h102;
    @(negedge clk);
    check("mis_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    mem_read_i = 1'b0;
    @(negedge clk);
    check("mis_flag", {31'd0, misalign_o}, 32'd1);
    check("mis_req",  {31'd0, dbus_req}, 32'd0);
    check("mis_ld",   load_data_o, 32'h0);
    @(negedge clk);
    check("mis_clear", {31'd0, misalign_o}, 32'd0);
`else
    txn("lh_odd", 1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'hABCD0000, 1,
        32'h100, 4'b1100, 32'h00000000, 32'hFFFFABCD, 1'b0);
    check("mis_tied", {31'd0, misalign_o}, 32'd0);
`endif

    txn("lbu_after", 1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h7F000000, 1,
        32'h200, 4'b1000, 32'h00000000, 32'h0000007F, 1'b0);

    repeat (3) @(negedge clk);
    check("req_q_empty", 32'(req_q.size()), 32'd0);
    check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
